// File: rtl/fifo_read_port_pkg.sv
// Shared definitions for the FIFO read port: data width, buffer occupancy
// encoding and the delivered-word counter width.
package fifo_read_port_pkg;

    localparam int DW = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL2 = 2'd2
    } occ_e;

    // One extra bit over the address width so a full depth's worth of reads is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry in-order output buffer with push/pop/flush; slot 0 always holds
// the oldest word so the head is a plain register read.
module fifo_skid_buf
    import fifo_read_port_pkg::*;
#(
    parameter int DW = fifo_read_port_pkg::DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    input  logic          flush,
    output occ_e          occ,
    output logic          valid,
    output logic [DW-1:0] head
);

    occ_e          occ_nxt;
    logic [DW-1:0] ent0, ent1;
    logic [1:0]    slot;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) occ <= EMPTY;
        else     occ <= occ_nxt;
    end

    always_comb begin
        occ_nxt = occ;
        if (flush) begin
            occ_nxt = EMPTY;
        end else begin
            case ({push, pop})
                2'b10: case (occ)
                    EMPTY:   occ_nxt = ONE;
                    ONE:     occ_nxt = FULL2;
                    default: occ_nxt = occ;
                endcase
                2'b01: case (occ)
                    FULL2:   occ_nxt = ONE;
                    default: occ_nxt = EMPTY;
                endcase
                default: occ_nxt = occ;
            endcase
        end
    end

    always_comb begin
        valid = (occ != EMPTY);
        head  = ent0;
    end

    // A new word lands in the first free slot after this cycle's pop has shifted.
    assign slot = occ - {1'b0, pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent0 <= '0;
            ent1 <= '0;
        end else if (!flush) begin
            if (pop && occ == FULL2) ent0 <= ent1;
            if (push) begin
                case (slot)
                    2'd0:    ent0 <= push_data;
                    2'd1:    ent1 <= push_data;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/fifo_read_port.sv
// FIFO read port: fetches words from a 1-cycle-latency FIFO into a 2-entry
// buffer and presents them on a valid/ready stream, counting deliveries.
module fifo_read_port
    import fifo_read_port_pkg::*;
#(
    parameter int depth = 32,
    parameter int DW    = fifo_read_port_pkg::DW,
    localparam int CW   = cnt_w(depth)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fifo_empty,
    input  logic          fifo_underflow,
    input  logic [DW-1:0] fifo_data,
    output logic          fifo_rd,
    input  logic          flush,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [CW-1:0] rd_count,
    output logic          err
);

    occ_e       occ;
    logic       infl;
    logic       run;
    logic       pop;
    logic       push;
    logic [2:0] lvl;

    assign pop  = m_valid & m_ready;
    assign push = infl & ~flush;
    assign lvl  = {1'b0, occ} + {2'b0, infl};

    // run keeps fetch off until the first clock edge after reset releases.
    assign fifo_rd = run & ~fifo_empty & ~flush & (lvl < (3'd2 + {2'b0, pop}));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run      <= 1'b0;
            infl     <= 1'b0;
            rd_count <= '0;
            err      <= 1'b0;
        end else begin
            run  <= 1'b1;
            infl <= fifo_rd;
            if (pop) rd_count <= rd_count + CW'(1);
            if (fifo_underflow || (fifo_rd && fifo_empty)) err <= 1'b1;
        end
    end

    fifo_skid_buf #(.DW(DW)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (fifo_data),
        .pop       (pop),
        .flush     (flush),
        .occ       (occ),
        .valid     (m_valid),
        .head      (m_data)
    );

endmodule

// File: tb/tb_fifo_read_port.sv
// Bench for fifo_read_port: a queue-backed FIFO, a queue-level model of the
// delivered stream checked every cycle, plus directed literal expectations.
module tb_fifo_read_port;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty = 1'b1;
    logic       fifo_underflow = 1'b0;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd;
    logic       flush = 1'b0;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic [5:0] rd_count;
    logic       err;

    int checks = 0;
    int errors = 0;

    logic [7:0] src_q[$];
    logic [7:0] mq[$];
    bit         m_pend = 0;
    logic [7:0] m_pend_d = 8'h00;
    bit         m_run = 0;
    int         m_cnt = 0;
    bit         m_err = 0;

    fifo_read_port #(.depth(32), .DW(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .fifo_data      (fifo_data),
        .fifo_rd        (fifo_rd),
        .flush          (flush),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .rd_count       (rd_count),
        .err            (err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Source FIFO plus the reference model, both advanced on the clock edge.
    always @(posedge clk) begin
        bit         pop;
        logic [7:0] rd_word;
        pop = (mq.size() != 0) && m_ready;
        rd_word = 8'hEE;
        if (fifo_rd && src_q.size() != 0) rd_word = src_q.pop_front();
        fifo_data  <= rd_word;
        fifo_empty <= (src_q.size() == 0);
        if (rst) begin
            mq.delete();
            m_pend = 0;
            m_run  = 0;
            m_cnt  = 0;
            m_err  = 0;
        end else begin
            m_run = 1;
            if (pop) m_cnt = (m_cnt + 1) % 64;
            if (fifo_underflow || (fifo_rd && fifo_empty)) m_err = 1;
            if (flush) begin
                mq.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (m_pend) mq.push_back(m_pend_d);
            end
            m_pend   = fifo_rd;
            m_pend_d = rd_word;
        end
    end

    always @(negedge clk) begin
        bit exp_valid, exp_pop, exp_rd;
        if (!rst) begin
            exp_valid = (mq.size() != 0);
            exp_pop   = exp_valid && m_ready;
            exp_rd    = m_run && !fifo_empty && !flush &&
                        ((int'(mq.size()) + int'(m_pend) - int'(exp_pop)) < 2);
            chk("fifo_rd", fifo_rd, exp_rd);
            chk("m_valid", m_valid, exp_valid);
            if (exp_valid) chk("m_data", m_data, mq[0]);
            chk("rd_count", rd_count, m_cnt);
            chk("err", err, m_err);
            chk("occ_infl_le2", (int'(dut.occ) + int'(dut.infl)) <= 2, 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int n, input int base);
        for (int i = 0; i < n; i++) src_q.push_back(8'(base + i));
        tick();
    endtask

    task automatic wait_idle(input int max_cyc, input bit toggle);
        bit idle = 0;
        for (int i = 0; i < max_cyc && !idle; i++) begin
            @(negedge clk);
            idle = (src_q.size() == 0) && (mq.size() == 0) && !m_pend && !m_valid;
            tick();
            if (toggle) m_ready = ~m_ready;
        end
        chk("idle_reached", idle, 1);
    endtask

    initial begin
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_rd_count", rd_count, 0);
        chk("rst_err", err, 0);
        chk("rst_fifo_rd", fifo_rd, 0);
        tick(); tick();
        rst = 1'b0;
        tick(); tick();

        // Three words, always ready: reads at 0-2, data at 2-4.
        begin
            logic       e_rd[6] = '{1, 1, 1, 0, 0, 0};
            logic       e_v[6]  = '{0, 0, 1, 1, 1, 0};
            logic [7:0] e_d[6]  = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
            m_ready = 1'b1;
            src_q.push_back(8'h11); src_q.push_back(8'h22); src_q.push_back(8'h33);
            tick();
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                chk($sformatf("basic_rd_c%0d", k), fifo_rd, e_rd[k]);
                chk($sformatf("basic_valid_c%0d", k), m_valid, e_v[k]);
                if (e_v[k]) chk($sformatf("basic_data_c%0d", k), m_data, e_d[k]);
                tick();
            end
            chk("basic_rd_count", rd_count, 3);
        end

        // Stalled consumer: only two reads issue, head word held.
        begin
            int n = 0;
            m_ready = 1'b0;
            load(5, 8'hA1);
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (fifo_rd) n++;
                tick();
            end
            @(negedge clk);
            chk("stall_rd_pulses", n, 2);
            chk("stall_valid", m_valid, 1);
            chk("stall_head", m_data, 8'hA1);
            tick();
            m_ready = 1'b1;
            wait_idle(40, 0);
            chk("stall_rd_count", rd_count, 8);
        end

        // Toggling ready over eight words.
        m_ready = 1'b1;
        load(8, 8'h50);
        wait_idle(60, 1);
        chk("toggle_rd_count", rd_count, 16);
        chk("toggle_err", err, 0);

        // Flush one cycle after the first read discards the in-flight word.
        m_ready = 1'b1;
        load(3, 8'hB0);
        @(negedge clk);
        chk("flush_rd_c0", fifo_rd, 1);
        chk("flush_valid_c0", m_valid, 0);
        tick();
        flush = 1'b1;
        @(negedge clk);
        chk("flush_rd_c1", fifo_rd, 0);
        chk("flush_valid_c1", m_valid, 0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_valid_c2", m_valid, 0);
        chk("flush_rd_c2", fifo_rd, 1);
        tick();
        @(negedge clk);
        chk("flush_valid_c3", m_valid, 0);
        tick();
        @(negedge clk);
        chk("flush_valid_c4", m_valid, 1);
        chk("flush_next_word", m_data, 8'hB1);
        tick();
        wait_idle(40, 0);
        chk("flush_rd_count", rd_count, 18);

        // Counter wrap: 18 + 46 = 64 deliveries.
        load(46, 0);
        wait_idle(200, 0);
        chk("wrap_rd_count", rd_count, 0);

        // Sticky error, then asynchronous reset mid-stream.
        m_ready = 1'b1;
        load(8, 8'hD0);
        fifo_underflow = 1'b1;
        tick();
        fifo_underflow = 1'b0;
        @(negedge clk);
        chk("uf_err_set", err, 1);
        tick(); tick();
        @(negedge clk);
        chk("uf_err_sticky", err, 1);
        chk("uf_midstream_valid", m_valid, 1);
        tick();
        rst = 1'b1;
        #1;
        chk("arst_m_valid", m_valid, 0);
        chk("arst_m_data", m_data, 0);
        chk("arst_rd_count", rd_count, 0);
        chk("arst_err", err, 0);
        chk("arst_fifo_rd", fifo_rd, 0);
        tick();
        @(negedge clk);
        chk("arst_held_fifo_rd", fifo_rd, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_no_early_rd", fifo_rd, 0);
        wait_idle(40, 0);
        chk("post_rst_err", err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_read_port.md
FIFO_READ_PORT -- requirements
Module: fifo_read_port

Interface
REQ-001 Parameter: depth, default 32, FIFO depth served; sizes the read counter.
REQ-002 Parameter: DW, default 8, data word width, matching the FIFO's 8-bit data path.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset. Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  FIFO empty status.
- fifo_underflow  input  1  FIFO underflow status.
- fifo_data  input  DW  FIFO read data; valid exactly one cycle after a cycle with fifo_rd=1.
- fifo_rd  output  1  read strobe to the FIFO.
- flush  input  1  synchronous discard of buffered and in-flight words.
- m_valid  output  DW-independent 1  downstream word available.
- m_ready  input  1  downstream accepts the word.
- m_data  output  DW  downstream word.
- rd_count  output  $clog2(depth)+1  words delivered downstream, modulo 2^width.
- err  output  1  sticky protocol error.

Function
REQ-010 The block SHALL hold a 2-entry output buffer: occ in {0,1,2} (states EMPTY, ONE, FULL2) plus one in-flight bit infl.
REQ-011 fifo_rd SHALL be combinational = !fifo_empty && !flush && (occ + infl - pop) < 2, where pop = m_valid && m_ready.
REQ-012 The in-flight bit SHALL register fifo_rd; when infl=1 and flush=0, fifo_data SHALL be written into the buffer that cycle.
REQ-013 m_valid SHALL equal (occ != 0); m_data SHALL be the oldest buffered word; order is strict FIFO order.
REQ-014 Transitions: push only -> occ+1; pop only -> occ-1; push and pop in the same cycle -> occ unchanged, new word behind the survivor.
REQ-015 Latency: FIFO non-empty with occ=0, infl=0 -> fifo_rd at cycle N, m_valid at N+2 (one cycle FIFO read, one cycle buffer register).
REQ-016 Throughput: with FIFO non-empty and m_ready held 1, one word SHALL be delivered per cycle after the initial latency.
REQ-017 m_data and m_valid SHALL be stable while m_valid=1 and m_ready=0 (no drop, no change).
REQ-018 occ + infl SHALL never exceed 2; a push into a full buffer cannot occur by construction, and the bench checks this as an assertion.
REQ-019 flush=1 SHALL set occ=0 next cycle, suppress fifo_rd, and discard any word in flight that cycle; rd_count does not count discarded words.
REQ-020 A pop SHALL increment rd_count by 1 and wrap from all-ones to 0.
REQ-021 err SHALL be set when fifo_underflow=1 or when fifo_rd=1 with fifo_empty=1, and SHALL stay set until reset.
REQ-022 pop and flush in the same cycle: flush wins for the buffer; the popped word SHALL still count in rd_count.

Reset
REQ-030 rst=1 SHALL immediately force occ=0, infl=0, m_valid=0, m_data=0, rd_count=0, err=0; fifo_rd=0 while rst=1.
REQ-031 Reset mid-transfer SHALL drop buffered and in-flight words; the first fifo_rd after rst falls SHALL occur no earlier than the first rising edge with rst=0.

Structure
REQ-040 A shared package SHALL hold DW, the occupancy encoding (EMPTY=0, ONE=1, FULL2=2), and the counter-width function.
REQ-041 One sub-module SHALL be used: fifo_skid_buf (2-entry buffer with push/pop/flush, occ output); the top holds the fetch control, counter and err.

Verification
REQ-050 FIFO preloaded with 0x11,0x22,0x33, m_ready=1 -> fifo_rd at cycles 0-2, m_data 0x11,0x22,0x33 at cycles 2-4, rd_count=3, m_valid=0 at cycle 5.
REQ-051 5 words, m_ready=0 for 10 cycles then 1 -> exactly 2 fifo_rd pulses while stalled, m_data held at word 0, then all 5 words in order.
REQ-052 m_ready toggles 1,0,1,0 on a FIFO of 8 words -> no loss or duplication, rd_count=8, err=0.
REQ-053 flush pulsed one cycle after the first fifo_rd -> m_valid stays 0, rd_count=0, the next delivered word is the FIFO's next entry.
REQ-054 fifo_underflow pulsed once -> err=1 and stays 1 until rst; rst asserted mid-stream -> all outputs 0 asynchronously.
REQ-055 rd_count width 6 (depth=32), 64 pops -> rd_count wraps to 0.
